// File: rtl/binbcd_seq.sv
// Sequential binary-to-BCD converter (double dabble). It handles one input bit per clock,
// then registers the result together with an overflow flag and a leading-zero blank mask.
module binbcd_seq #(
  parameter int BIN_W  = 11,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CW-1:0]     LAST      = CW'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                       state_q, state_d;
  logic [BIN_W-1:0]             sr_q, sr_d;
  logic [DIGITS-1:0][3:0]       bcd_q, bcd_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         ovfw_q, ovfw_d;
  logic [DIGITS-1:0][3:0]       out_q, out_d;
  logic                         ovf_q, ovf_d;
  logic [DIGITS-1:0]            blank_q, blank_d;
  logic                         valid_q, valid_d;

  logic [DIGITS-1:0][3:0]       adj;
  logic [DIGITS-1:0][3:0]       shifted;
  logic                         carry;
  logic [DIGITS-1:0]            blank_new;

  // Pre-shift correction so every digit doubles into a legal BCD digit plus carry.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[g] = (bcd_q[g] >= 4'd5) ? bcd_q[g] + 4'd3 : bcd_q[g];
  end

  // Bit falling off the top digit is a 10^DIGITS carry; dropping it leaves value mod 10^DIGITS.
  assign {carry, shifted} = {adj, sr_q[BIN_W-1]};

  always_comb begin
    logic allz;
    allz      = 1'b1;
    blank_new = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allz         = allz & (bcd_q[i] == 4'd0);
      blank_new[i] = allz;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovfw_d  = ovfw_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          ovfw_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d  = shifted;
        sr_d   = sr_q << 1;
        ovfw_d = ovfw_q | carry;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_d   = bcd_q;
        ovf_d   = ovfw_q;
        blank_d = blank_new;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovfw_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      blank_q <= BLANK_RST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovfw_q  <= ovfw_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign valid   = valid_q;
  assign bcd_out = out_q;
  assign ovf     = ovf_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_binbcd_seq.sv
// Bench for binbcd_seq: three configurations (11/4, 11/3, 1/1) share one stimulus bus and are
// compared against an arithmetic decimal model.
module tb_binbcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] bin;

  logic        busy0, valid0, ovf0;
  logic [15:0] bcd0;
  logic [3:0]  blank0;
  logic        busy3, valid3, ovf3;
  logic [11:0] bcd3;
  logic [2:0]  blank3;
  logic        busy1, valid1, ovf1;
  logic [3:0]  bcd1;
  logic [0:0]  blank1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  binbcd_seq #(.BIN_W(11), .DIGITS(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin),
    .busy(busy0), .valid(valid0), .bcd_out(bcd0), .ovf(ovf0), .blank(blank0));

  binbcd_seq #(.BIN_W(11), .DIGITS(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin),
    .busy(busy3), .valid(valid3), .bcd_out(bcd3), .ovf(ovf3), .blank(blank3));

  binbcd_seq #(.BIN_W(1), .DIGITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin[0:0]),
    .busy(busy1), .valid(valid1), .bcd_out(bcd1), .ovf(ovf1), .blank(blank1));

  typedef struct {
    logic [10:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } vec_t;

  // Decimal model: plain division by ten, no shift/add-3 mechanics.
  function automatic logic [63:0] ref_bcd(longint unsigned v, int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(longint unsigned v, int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return v >= p;
  endfunction

  function automatic logic [63:0] ref_blank(logic [63:0] b, int d);
    logic [63:0] m;
    m = '0;
    for (int i = 1; i < d; i++) m[i] = ((b >> (4*i)) == 64'd0);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion on all three DUTs; outputs are checked after they have settled and held.
  task automatic convert(input logic [10:0] v);
    int lat0, lat3, lat1, np0, np3, np1;
    lat0 = -1; lat3 = -1; lat1 = -1; np0 = 0; np3 = 0; np1 = 0;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 11'($urandom);
    chk("busy_after_E0", busy0, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (valid0) begin np0++; if (lat0 < 0) lat0 = n; end
      if (valid3) begin np3++; if (lat3 < 0) lat3 = n; end
      if (valid1) begin np1++; if (lat1 < 0) lat1 = n; end
    end
    chk("lat_d4", 64'(lat0), 64'd12);
    chk("pulses_d4", 64'(np0), 64'd1);
    chk("lat_d3", 64'(lat3), 64'd12);
    chk("pulses_d3", 64'(np3), 64'd1);
    chk("lat_d1", 64'(lat1), 64'd2);
    chk("pulses_d1", 64'(np1), 64'd1);
    chk("busy_idle", busy0, 1'b0);
    chk("bcd_d4", bcd0, ref_bcd(v, 4));
    chk("ovf_d4", ovf0, ref_ovf(v, 4));
    chk("blank_d4", blank0, ref_blank(ref_bcd(v, 4), 4));
    chk("bcd_d3", bcd3, ref_bcd(v, 3));
    chk("ovf_d3", ovf3, ref_ovf(v, 3));
    chk("blank_d3", blank3, ref_blank(ref_bcd(v, 3), 3));
    chk("bcd_d1", bcd1, ref_bcd(v[0], 1));
    chk("ovf_d1", ovf1, 1'b0);
    chk("blank_d1", blank1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int   cyc, due, free_at, npulse;
    logic [10:0] acc, cur;

    tbl[0] = '{11'd2047, 16'h2047, 1'b0, 4'b0000};
    tbl[1] = '{11'd0,    16'h0000, 1'b0, 4'b1110};
    tbl[2] = '{11'd7,    16'h0007, 1'b0, 4'b1110};
    tbl[3] = '{11'd1234, 16'h1234, 1'b0, 4'b0000};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) tick();
    chk("rst_busy", busy0, 1'b0);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_bcd", bcd0, 16'h0);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_blank", blank0, 4'b1110);
    chk("rst_blank_d3", blank3, 3'b110);
    chk("rst_blank_d1", blank1, 1'b0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      convert(tbl[i].bin);
      chk("tbl_bcd", bcd0, tbl[i].bcd);
      chk("tbl_ovf", ovf0, tbl[i].ovf);
      chk("tbl_blank", blank0, tbl[i].blank);
    end

    convert(11'd1000);
    chk("d3_1000_bcd", bcd3, 12'h000);
    chk("d3_1000_ovf", ovf3, 1'b1);
    chk("d3_1000_blank", blank3, 3'b110);
    convert(11'd999);
    chk("d3_999_bcd", bcd3, 12'h999);
    chk("d3_999_ovf", ovf3, 1'b0);
    chk("d3_999_blank", blank3, 3'b000);
    convert(11'd0);
    chk("d1_0_bcd", bcd1, 4'h0);
    convert(11'd1);
    chk("d1_1_bcd", bcd1, 4'h1);

    // start held high with bin changing every cycle; model derives accept edges from timing rules.
    start   = 1'b1;
    cyc     = 0;
    free_at = 1;
    due     = -1;
    npulse  = 0;
    acc     = '0;
    repeat (70) begin
      cur = 11'($urandom);
      bin = cur;
      tick();
      cyc++;
      if (cyc >= free_at) begin
        acc     = cur;
        due     = cyc + 12;
        free_at = cyc + 13;
      end
      chk("b2b_valid", valid0, (cyc == due) ? 1'b1 : 1'b0);
      if (cyc == due) begin
        npulse++;
        chk("b2b_bcd", bcd0, ref_bcd(acc, 4));
        chk("b2b_blank", blank0, ref_blank(ref_bcd(acc, 4), 4));
      end
    end
    chk("b2b_npulse", 64'(npulse), 64'd5);
    start = 1'b0;
    repeat (15) tick();

    // Reset in the middle of converting 2047.
    start = 1'b1;
    bin   = 11'd2047;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_valid", valid0, 1'b0);
    chk("mid_rst_bcd", bcd0, 16'h0);
    chk("mid_rst_ovf", ovf0, 1'b0);
    chk("mid_rst_blank", blank0, 4'b1110);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("mid_rst_no_valid", valid0, 1'b0);
    end
    #3 rst_n = 1'b1;
    convert(11'd42);
    chk("after_rst_bcd", bcd0, 16'h0042);
    chk("after_rst_blank", blank0, 4'b1100);

    for (int v = 0; v < 2048; v++) convert(11'(v));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
